// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman systolic array controller.
package sw_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StDone
    } sw_state_e;

    localparam logic [1:0] BaseA = 2'd0;
    localparam logic [1:0] BaseC = 2'd1;
    localparam logic [1:0] BaseG = 2'd2;
    localparam logic [1:0] BaseT = 2'd3;

    localparam int InitEDefault = -512;

endpackage

// File: rtl/sw_max_tracker.sv
// Signed running maximum of the last-PE score, with optional position capture.
// Define SW_CTRL_POS_EN to track the reference index of the best score.
module sw_max_tracker #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned REF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 track,
    input  logic [WIDTH-1:0]     score,
    output logic [WIDTH-1:0]     max_score,
    output logic [REF_CNT_W-1:0] max_pos
);

    logic better;

    // Strict compare so ties keep the earlier position.
    assign better = track && ($signed(score) > $signed(max_score));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_score <= '0;
        end else if (better) begin
            max_score <= score;
        end
    end

`ifdef SW_CTRL_POS_EN
    logic [REF_CNT_W-1:0] pos_cnt;

    // Counts reference bases as their scores leave the array.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos_cnt <= '0;
            max_pos <= '0;
        end else if (track) begin
            pos_cnt <= pos_cnt + 1'b1;
            if (better) begin
                max_pos <= pos_cnt;
            end
        end
    end
`else
    assign max_pos = '0;
`endif

endmodule

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear systolic Smith-Waterman PE array: query load, reference stream, drain.
// Define SW_CTRL_POS_EN to report the reference position of the best score on max_pos.
module sw_array_ctrl
    import sw_pkg::*;
#(
    parameter int unsigned NUM_PE    = 64,
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned REF_CNT_W = 16,
    parameter int          INIT_V    = 0,
    parameter int          INIT_E    = InitEDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    input  logic                 q_valid,
    input  logic [1:0]           q_base,
    output logic                 q_ready,
    input  logic                 r_valid,
    input  logic [1:0]           r_base,
    input  logic                 r_last,
    output logic                 r_ready,
    output logic                 arr_stall,
    output logic [1:0]           arr_S,
    output logic                 arr_store_S,
    output logic [1:0]           arr_T,
    output logic                 arr_init,
    output logic [WIDTH-1:0]     arr_init_V,
    output logic [WIDTH-1:0]     arr_init_E,
    input  logic [WIDTH-1:0]     last_V,
    input  logic                 last_init,
    output logic                 done,
    output logic [WIDTH-1:0]     max_score,
    output logic [REF_CNT_W-1:0] max_pos
);

    localparam int unsigned    CntW    = $clog2(NUM_PE + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(NUM_PE - 1);

    sw_state_e       state;
    logic [CntW-1:0] cnt;
    logic            job_start;
    logic            track;

    assign job_start  = (state == StIdle) && start;
    assign track      = !arr_stall && last_init;
    assign arr_init_V = WIDTH'(INIT_V);
    assign arr_init_E = WIDTH'(INIT_E);

    // cnt counts query acceptances in StLoad and drain cycles in StDrain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= '0;
            busy        <= 1'b0;
            q_ready     <= 1'b0;
            r_ready     <= 1'b0;
            arr_stall   <= 1'b0;
            arr_S       <= 2'd0;
            arr_store_S <= 1'b0;
            arr_T       <= 2'd0;
            arr_init    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    arr_stall   <= 1'b0;
                    arr_store_S <= 1'b0;
                    arr_init    <= 1'b0;
                    arr_S       <= 2'd0;
                    arr_T       <= 2'd0;
                    if (start) begin
                        state   <= StLoad;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        q_ready <= 1'b1;
                    end
                end
                StLoad: begin
                    if (q_valid) begin
                        arr_S       <= q_base;
                        arr_store_S <= 1'b1;
                        arr_stall   <= 1'b0;
                        if (cnt == CntLast) begin
                            state   <= StRun;
                            cnt     <= '0;
                            q_ready <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // Freeze the whole chain so the partial query shift stays aligned.
                        arr_stall <= 1'b1;
                    end
                end
                StRun: begin
                    arr_store_S <= 1'b0;
                    if (r_valid) begin
                        arr_T     <= r_base;
                        arr_init  <= 1'b1;
                        arr_stall <= 1'b0;
                        if (r_last) begin
                            state   <= StDrain;
                            cnt     <= '0;
                            r_ready <= 1'b0;
                        end
                    end else begin
                        arr_stall <= 1'b1;
                    end
                end
                StDrain: begin
                    arr_init  <= 1'b0;
                    arr_T     <= 2'd0;
                    arr_stall <= 1'b0;
                    if (cnt == CntLast) begin
                        state <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    // The last base's score is tracked on this same edge.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sw_max_tracker #(
        .WIDTH    (WIDTH),
        .REF_CNT_W(REF_CNT_W)
    ) u_max_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (job_start),
        .track    (track),
        .score    (last_V),
        .max_score(max_score),
        .max_pos  (max_pos)
    );

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl with a 4-PE behavioural delay-line model of the array.
module tb_sw_array_ctrl;
    import sw_pkg::*;

`ifdef SW_CTRL_POS_EN
    localparam bit PosEn = 1'b1;
`else
    localparam bit PosEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        q_valid;
    logic [1:0]  q_base;
    logic        q_ready;
    logic        r_valid;
    logic [1:0]  r_base;
    logic        r_last;
    logic        r_ready;
    logic        arr_stall;
    logic [1:0]  arr_S;
    logic        arr_store_S;
    logic [1:0]  arr_T;
    logic        arr_init;
    logic [9:0]  arr_init_V;
    logic [9:0]  arr_init_E;
    logic [9:0]  last_V;
    logic        last_init;
    logic        done;
    logic [9:0]  max_score;
    logic [15:0] max_pos;

    int chk = 0;
    int fail = 0;
    int stall_cnt;
    int done_cnt;

    sw_array_ctrl #(
        .NUM_PE   (4),
        .WIDTH    (10),
        .REF_CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .q_valid    (q_valid),
        .q_base     (q_base),
        .q_ready    (q_ready),
        .r_valid    (r_valid),
        .r_base     (r_base),
        .r_last     (r_last),
        .r_ready    (r_ready),
        .arr_stall  (arr_stall),
        .arr_S      (arr_S),
        .arr_store_S(arr_store_S),
        .arr_T      (arr_T),
        .arr_init   (arr_init),
        .arr_init_V (arr_init_V),
        .arr_init_E (arr_init_E),
        .last_V     (last_V),
        .last_init  (last_init),
        .done       (done),
        .max_score  (max_score),
        .max_pos    (max_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: every PE is one register stage that freezes on arr_stall.
    // Column scores (best cell of each reference column) are hand-computed per test.
    logic [3:0] pipe_init;
    logic [9:0] pipe_v [4];
    logic [9:0] col_score [4];
    logic [7:0] q_chain;
    logic [7:0] ref_log;
    int         cap_idx;

    assign last_init = pipe_init[3];
    assign last_V    = pipe_v[3];

    always @(posedge clk) begin
        if (rst) begin
            pipe_init <= '0;
            for (int k = 0; k < 4; k++) pipe_v[k] <= '0;
            cap_idx <= 0;
        end else begin
            if (start && !busy) cap_idx <= 0;
            if (!arr_stall) begin
                pipe_init <= {pipe_init[2:0], arr_init};
                pipe_v[0] <= (arr_init && cap_idx < 4) ? col_score[cap_idx] : 10'd0;
                for (int k = 1; k < 4; k++) pipe_v[k] <= pipe_v[k-1];
                if (arr_init) begin
                    ref_log <= {ref_log[5:0], arr_T};
                    cap_idx <= cap_idx + 1;
                end
                if (arr_store_S) q_chain <= {q_chain[5:0], arr_S};
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (arr_stall) stall_cnt++;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cols(input logic [9:0] c0, input logic [9:0] c1,
                            input logic [9:0] c2, input logic [9:0] c3);
        col_score[0] = c0;
        col_score[1] = c1;
        col_score[2] = c2;
        col_score[3] = c3;
    endtask

    // Runs one 4-base job; returns the number of cycles from r_last acceptance to done.
    task automatic run_job(input logic [7:0] q, input logic [7:0] r, input int q_gap,
                           input int r_gap_at, input int r_gap_len, input int start_at,
                           output int wait_n);
        stall_cnt = 0;
        done_cnt  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (q_gap) step();
            q_valid = 1'b1;
            q_base  = q[7-2*i -: 2];
            step();
            q_valid = 1'b0;
        end
        for (int j = 0; j < 4; j++) begin
            if (j == r_gap_at) begin
                r_valid = 1'b0;
                repeat (r_gap_len) step();
            end
            r_valid = 1'b1;
            r_base  = r[7-2*j -: 2];
            r_last  = (j == 3);
            start   = (j == start_at);
            step();
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        start   = 1'b0;
        wait_n  = 0;
        while (done_cnt == 0 && wait_n < 40) begin
            step();
            wait_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk++; if (busy !== 1'b0) begin fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        chk++; if (q_ready !== 1'b0) begin fail++; $display("FAIL rst_q_ready: got %b expected 0", q_ready); end
        chk++; if (r_ready !== 1'b0) begin fail++; $display("FAIL rst_r_ready: got %b expected 0", r_ready); end
        chk++; if (arr_stall !== 1'b0) begin fail++; $display("FAIL rst_stall: got %b expected 0", arr_stall); end
        chk++; if (arr_store_S !== 1'b0 || arr_S !== 2'd0) begin fail++; $display("FAIL rst_S: got %b/%0d expected 0/0", arr_store_S, arr_S); end
        chk++; if (arr_init !== 1'b0 || arr_T !== 2'd0) begin fail++; $display("FAIL rst_T: got %b/%0d expected 0/0", arr_init, arr_T); end
        chk++; if (done !== 1'b0) begin fail++; $display("FAIL rst_done: got %b expected 0", done); end
        chk++; if (max_score !== 10'd0 || max_pos !== 16'd0) begin fail++; $display("FAIL rst_max: got %0d/%0d expected 0/0", max_score, max_pos); end
        chk++; if (arr_init_V !== 10'd0) begin fail++; $display("FAIL init_V: got %h expected 000", arr_init_V); end
        chk++; if (arr_init_E !== 10'h200) begin fail++; $display("FAIL init_E: got %h expected 200", arr_init_E); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int w;
        set_cols(10'd2, 10'd4, 10'd6, 10'd8);
        run_job({BaseA, BaseC, BaseG, BaseT}, {BaseA, BaseC, BaseG, BaseT}, 0, -1, 0, -1, w);
        chk++; if (w !== 6) begin fail++; $display("FAIL basic_latency: got %0d expected 6", w); end
        chk++; if (done_cnt !== 1) begin fail++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
        chk++; if (stall_cnt !== 0) begin fail++; $display("FAIL basic_stall: got %0d expected 0", stall_cnt); end
        chk++; if (max_score !== 10'd8) begin fail++; $display("FAIL basic_score: got %0d expected 8", max_score); end
        chk++; if (max_pos !== (PosEn ? 16'd3 : 16'd0)) begin fail++; $display("FAIL basic_pos: got %0d expected %0d", max_pos, PosEn ? 3 : 0); end
        chk++; if (q_chain !== 8'b00_01_10_11) begin fail++; $display("FAIL basic_query: got %b expected 00011011", q_chain); end
        chk++; if (ref_log !== 8'b00_01_10_11) begin fail++; $display("FAIL basic_ref: got %b expected 00011011", ref_log); end
        chk++; if (busy !== 1'b0) begin fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_query_gaps();
        int w;
        set_cols(10'd2, 10'd4, 10'd6, 10'd8);
        run_job({BaseA, BaseG, BaseC, BaseT}, {BaseA, BaseG, BaseC, BaseT}, 2, -1, 0, -1, w);
        chk++; if (stall_cnt !== 6) begin fail++; $display("FAIL qgap_stall: got %0d expected 6", stall_cnt); end
        chk++; if (q_chain !== 8'b00_10_01_11) begin fail++; $display("FAIL qgap_query: got %b expected 00100111", q_chain); end
        chk++; if (w !== 6) begin fail++; $display("FAIL qgap_latency: got %0d expected 6", w); end
        chk++; if (max_score !== 10'd8) begin fail++; $display("FAIL qgap_score: got %0d expected 8", max_score); end
        chk++; if (max_pos !== (PosEn ? 16'd3 : 16'd0)) begin fail++; $display("FAIL qgap_pos: got %0d expected %0d", max_pos, PosEn ? 3 : 0); end
    endtask

    task automatic test_ties();
        int w;
        set_cols(10'd2, 10'd2, 10'd2, 10'd2);
        run_job({BaseA, BaseC, BaseG, BaseT}, {BaseG, BaseG, BaseG, BaseG}, 0, -1, 0, -1, w);
        chk++; if (max_score !== 10'd2) begin fail++; $display("FAIL tie_score: got %0d expected 2", max_score); end
        chk++; if (max_pos !== 16'd0) begin fail++; $display("FAIL tie_pos: got %0d expected 0", max_pos); end
        chk++; if (ref_log !== 8'b10_10_10_10) begin fail++; $display("FAIL tie_ref: got %b expected 10101010", ref_log); end
    endtask

    task automatic test_ref_stall();
        int w;
        set_cols(10'd2, 10'd4, 10'd6, 10'd8);
        run_job({BaseA, BaseC, BaseG, BaseT}, {BaseA, BaseC, BaseG, BaseT}, 0, 2, 3, -1, w);
        chk++; if (stall_cnt !== 3) begin fail++; $display("FAIL rstall_stall: got %0d expected 3", stall_cnt); end
        chk++; if (w !== 6) begin fail++; $display("FAIL rstall_latency: got %0d expected 6", w); end
        chk++; if (max_score !== 10'd8) begin fail++; $display("FAIL rstall_score: got %0d expected 8", max_score); end
        chk++; if (max_pos !== (PosEn ? 16'd3 : 16'd0)) begin fail++; $display("FAIL rstall_pos: got %0d expected %0d", max_pos, PosEn ? 3 : 0); end
        chk++; if (ref_log !== 8'b00_01_10_11) begin fail++; $display("FAIL rstall_ref: got %b expected 00011011", ref_log); end
    endtask

    task automatic test_start_in_run();
        int w;
        set_cols(10'd3, 10'd7, 10'd5, 10'd1);
        run_job({BaseA, BaseC, BaseG, BaseT}, {BaseT, BaseA, BaseC, BaseC}, 0, -1, 0, 1, w);
        repeat (10) step();
        chk++; if (done_cnt !== 1) begin fail++; $display("FAIL sir_done: got %0d expected 1", done_cnt); end
        chk++; if (busy !== 1'b0) begin fail++; $display("FAIL sir_busy: got %b expected 0", busy); end
        chk++; if (max_score !== 10'd7) begin fail++; $display("FAIL sir_score: got %0d expected 7", max_score); end
        chk++; if (max_pos !== (PosEn ? 16'd1 : 16'd0)) begin fail++; $display("FAIL sir_pos: got %0d expected %0d", max_pos, PosEn ? 1 : 0); end
    endtask

    task automatic test_reset_in_load();
        int w;
        start = 1'b1;
        step();
        start   = 1'b0;
        q_valid = 1'b1;
        q_base  = BaseG;
        step();
        q_valid = 1'b0;
        chk++; if (arr_store_S !== 1'b1 || arr_S !== BaseG) begin fail++; $display("FAIL rload_pre: got %b/%0d expected 1/2", arr_store_S, arr_S); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk++; if (busy !== 1'b0 || q_ready !== 1'b0) begin fail++; $display("FAIL rload_busy: got %b/%b expected 0/0", busy, q_ready); end
        chk++; if (arr_store_S !== 1'b0 || arr_S !== 2'd0 || arr_stall !== 1'b0) begin fail++; $display("FAIL rload_arr: got %b/%0d/%b expected 0/0/0", arr_store_S, arr_S, arr_stall); end
        rst = 1'b0;
        step();
        set_cols(10'd2, 10'd4, 10'd6, 10'd8);
        run_job({BaseA, BaseC, BaseG, BaseT}, {BaseA, BaseC, BaseG, BaseT}, 0, -1, 0, -1, w);
        chk++; if (w !== 6 || done_cnt !== 1) begin fail++; $display("FAIL rload_job_done: got %0d/%0d expected 6/1", w, done_cnt); end
        chk++; if (max_score !== 10'd8) begin fail++; $display("FAIL rload_score: got %0d expected 8", max_score); end
        chk++; if (q_chain !== 8'b00_01_10_11) begin fail++; $display("FAIL rload_query: got %b expected 00011011", q_chain); end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        q_valid = 1'b0;
        q_base  = 2'd0;
        r_valid = 1'b0;
        r_base  = 2'd0;
        r_last  = 1'b0;
        set_cols(10'd0, 10'd0, 10'd0, 10'd0);
        test_reset();
        test_basic();
        test_query_gaps();
        test_ties();
        test_ref_stall();
        test_start_in_run();
        test_reset_in_load();
        $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sw_array_ctrl.md
Name: sw_array_ctrl

Overview:
- Sequencer for a linear systolic array of Smith-Waterman PEs with affine gaps.
- Per alignment job it:
  - shifts the query bases into the PE chain using the S/store_S shift path;
  - streams reference bases with the T/init shift path;
  - stalls the array whenever input starves;
  - drains the wavefront.
- Watches the last PE's score to report the best local alignment score for the job.
- Sits between the sequence-fetch logic and PE0 of the array.

Parameters:
- NUM_PE, 64, number of PEs in the chain; equals the query length.
- WIDTH, 10, score width in bits, matches the PE score width.
- REF_CNT_W, 16, width of the reference position counter.
- INIT_V, 0, value driven on init_V.
- INIT_E, -512, value driven on init_E (two's complement, WIDTH bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin job; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- q_valid  in  1  query base valid
- q_base  in  2  query base
- q_ready  out  1  query base accepted when q_valid&&q_ready
- r_valid  in  1  reference base valid
- r_base  in  2  reference base
- r_last  in  1  final reference base of job
- r_ready  out  1  reference base accepted when r_valid&&r_ready
- arr_stall  out  1  array-wide stall
- arr_S  out  2  query base into PE0
- arr_store_S  out  1  query store strobe into PE0
- arr_T  out  2  reference base into PE0
- arr_init  out  1  computation-active into PE0
- arr_init_V  out  WIDTH  constant INIT_V
- arr_init_E  out  WIDTH  constant INIT_E
- last_V  in  WIDTH  V_out of PE NUM_PE-1 (signed)
- last_init  in  1  init_out of PE NUM_PE-1
- done  out  1  one-cycle pulse; result valid
- max_score  out  WIDTH  best score of the finished job, held until next start
- max_pos  out  REF_CNT_W  reference index at which max_score left the array

Behaviour:
- All controls are registered outputs.
- Reset values: busy=0, q_ready=0, r_ready=0, arr_stall=0, arr_S=0, arr_store_S=0, arr_T=0, arr_init=0, done=0, max_score=0, max_pos=0.
- State IDLE:
  - All array strobes are 0 and arr_stall=0.
  - start → LOAD. Entering LOAD clears the load counter, max_score, max_pos and the reference counter.
- State LOAD:
  - q_ready=1.
  - On an accepted query base: arr_S=q_base, arr_store_S=1, arr_stall=0, load counter increments.
  - With no q_valid: arr_stall=1 and arr_store_S is held. The whole array freezes, so the partial shift stays aligned.
  - The first accepted base ends up in PE NUM_PE-1.
  - After the NUM_PE-th acceptance, arr_store_S=0 and the next state is RUN.
- State RUN:
  - r_ready=1.
  - On an accepted base: arr_T=r_base, arr_init=1, arr_stall=0, reference counter increments.
  - With no r_valid: arr_stall=1 and arr_T/arr_init are held.
  - Accepting r_last → DRAIN.
- State DRAIN:
  - r_ready=0, arr_init=0, arr_T=0, arr_stall=0.
  - Runs exactly NUM_PE cycles, then → DONE.
- State DONE: done=1 for one cycle, then → IDLE.
- Score tracking:
  - Active in any cycle with arr_stall=0 and last_init=1.
  - Signed compare; if last_V > max_score, update max_score. Ties keep the earlier position.
- Latency:
  - The score for reference base j leaves the last PE NUM_PE unstalled cycles after base j is accepted.
  - max_pos = j (0-based) of the winning base.
- start while busy is ignored.
- A zero-length reference cannot occur: r_last on the first base gives a 1-base job.
- rst mid-job: the controller returns to IDLE on the next edge. Array contents are don't-care because PE rst is shared.

Optional Feature:
- Macro: SW_CTRL_POS_EN.
- Defined: max_pos is tracked as above, using a REF_CNT_W-bit delayed position counter that increments on each tracked last_init cycle.
- Undefined: the counter and compare-position logic are omitted, and max_pos is tied to 0. max_score is unaffected.

Decomposition:
- Shared package sw_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DRAIN, DONE);
  - the 2-bit base encoding constants A=0, C=1, G=2, T=3;
  - the default INIT_E constant.
- One sub-module, sw_max_tracker: the signed max compare and the optional position counter.

Test Plan:
- NUM_PE=4, query ACGT, then reference ACGT with r_last on the fourth base → done after 4 drain cycles; max_score=8, max_pos=3.
- Query load with q_valid gaps of 2 cycles → arr_stall=1 exactly during the gaps; final query AGCT still aligns as if fed without gaps (same result as above).
- Reference GGGG against query ACGT → max_score=2, max_pos=0 (first of the tied single-G matches).
- r_valid drops for 3 cycles mid-RUN → arr_stall=1 for those 3 cycles; score and position identical to an unstalled run.
- start pulsed during RUN → ignored; done pulses once, with a single job's result.
- rst asserted in LOAD → next cycle busy=0 and all outputs at reset values; a fresh start completes normally.
